wave_oscillator: RTL and testbench

Multi-mode, parametrised phase-accumulator oscillator that generates one signed audio sample stream over an AXI-Stream-style valid/ready interface. It is the next generation of the single-mode saw/square oscillator. New features: selectable data and phase widths, triangle and noise modes, glitch-free configuration updates at period boundaries, a phase-sync input and a period-start marker. It sits at the head of the synthesis chain and feeds the oversampling filter/decimator.

---
 rtl/wave_oscillator.sv | 127 ++++++++++++
 tb/tb_wave_oscillator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_oscillator.sv
// Phase-accumulator oscillator (saw/square/triangle/noise) with a valid/ready sample stream.
// Active configuration is re-latched only at period boundaries so mid-period input changes never glitch.
module wave_oscillator #(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int DUTY_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PHASE_WIDTH-1:0] divisor,
    input  logic [DUTY_WIDTH-1:0]  duty,
    input  logic [1:0]             mode,
    input  logic                   enable,
    input  logic                   sync,
    output logic                   tvalid,
    output logic [DATA_WIDTH-1:0]  tdata,
    output logic                   tuser,
    input  logic                   tready
);

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_NOISE  = 2'd3
    } mode_e;

    localparam logic [31:0]           LFSR_SEED = 32'h0000_0001;
    localparam logic [31:0]           LFSR_TAPS = 32'h8020_0003;
    localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MOST_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic                   tuser_q, tuser_d;
    logic                   tvalid_q, tvalid_d;
    logic                   sync_pend_q, sync_pend_d;
    logic [PHASE_WIDTH-1:0] div_a_q, div_a_d;
    logic [DUTY_WIDTH-1:0]  duty_a_q, duty_a_d;
    mode_e                  mode_a_q, mode_a_d;

    logic                   xfer;
    logic [PHASE_WIDTH:0]   sum;
    logic                   wrap;
    logic [31:0]            lfsr_step;
    logic                   cfg_load;

    always_comb begin
        xfer      = tvalid_q & tready;
        sum       = {1'b0, acc_q} + {1'b0, div_a_q};
        // A pending sync counts as a period boundary even without a carry.
        wrap      = sync_pend_q | sum[PHASE_WIDTH];
        lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

        acc_d       = acc_q;
        lfsr_d      = lfsr_q;
        tuser_d     = tuser_q;
        div_a_d     = div_a_q;
        duty_a_d    = duty_a_q;
        mode_a_d    = mode_a_q;

        if (xfer) begin
            acc_d   = sync_pend_q ? '0 : sum[PHASE_WIDTH-1:0];
            tuser_d = wrap;
            if (wrap) begin
                lfsr_d = lfsr_step;
            end
        end

        sync_pend_d = (sync_pend_q & ~xfer) | sync;
        tvalid_d    = tvalid_q ? ~(xfer & ~enable) : enable;

        cfg_load = ~tvalid_q | (xfer & wrap);
        if (cfg_load) begin
            div_a_d  = divisor;
            duty_a_d = duty;
            mode_a_d = mode_e'(mode);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            tuser_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            sync_pend_q <= 1'b0;
            div_a_q     <= divisor;
            duty_a_q    <= duty;
            mode_a_q    <= mode_e'(mode);
        end else begin
            acc_q       <= acc_d;
            lfsr_q      <= lfsr_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            sync_pend_q <= sync_pend_d;
            div_a_q     <= div_a_d;
            duty_a_q    <= duty_a_d;
            mode_a_q    <= mode_a_d;
        end
    end

    logic [DATA_WIDTH-1:0] saw_t;
    logic [DATA_WIDTH-1:0] tri_u;
    logic [DATA_WIDTH-1:0] tri_v;
    logic                  unused_bits;

    assign saw_t       = acc_q[PHASE_WIDTH-1 -: DATA_WIDTH];
    assign tri_u       = acc_q[PHASE_WIDTH-2 -: DATA_WIDTH];
    assign tri_v       = acc_q[PHASE_WIDTH-1] ? ~tri_u : tri_u;
    assign unused_bits = ^{acc_q, lfsr_q};

    always_comb begin
        tdata = MOST_NEG;
        case (mode_a_q)
            MODE_SAW:    tdata = saw_t ^ MOST_NEG;
            MODE_SQUARE: tdata = (acc_q[PHASE_WIDTH-1 -: DUTY_WIDTH] < duty_a_q) ? MOST_POS : MOST_NEG;
            MODE_TRI:    tdata = tri_v ^ MOST_NEG;
            MODE_NOISE:  tdata = lfsr_q[DATA_WIDTH-1:0];
            default:     tdata = MOST_NEG;
        endcase
    end

    assign tvalid = tvalid_q;
    assign tuser  = tuser_q;

endmodule

// File: tb/tb_wave_oscillator.sv
// Directed bench for wave_oscillator: expected samples are queued as stimulus is set up
// and popped on every observed handshake.
module tb_wave_oscillator;

    localparam int DW = 16;
    localparam int PW = 32;
    localparam int QW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [PW-1:0] divisor = '0;
    logic [QW-1:0] duty = '0;
    logic [1:0]    mode = 2'd0;
    logic          enable = 1'b1;
    logic          sync = 1'b0;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tuser;
    logic          tready = 1'b1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wave_oscillator #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .DUTY_WIDTH(QW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .divisor (divisor),
        .duty    (duty),
        .mode    (mode),
        .enable  (enable),
        .sync    (sync),
        .tvalid  (tvalid),
        .tdata   (tdata),
        .tuser   (tuser),
        .tready  (tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic u);
        exp_t e;
        e.data = d;
        e.user = u;
        sb_q.push_back(e);
    endtask

    // Compare the sample about to be transferred, then advance one clock.
    task automatic cycle();
        exp_t e;
        if (tvalid && tready) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow observed data %0h user %0b expected no sample", tdata, tuser);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sample_data", 32'(tdata), 32'(e.data));
                chk("sample_user", 32'(tuser), 32'(e.user));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain_check(input string tag);
        chk(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_reset(input logic [PW-1:0] div, input logic [QW-1:0] dty, input logic [1:0] md);
        sb_q.delete();
        divisor = div;
        duty    = dty;
        mode    = md;
        enable  = 1'b1;
        sync    = 1'b0;
        tready  = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tuser", 32'(tuser), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_tvalid", 32'(tvalid), 1);
    endtask

    logic [DW-1:0] tri_tab [16];

    initial begin
        tri_tab = '{16'h8000, 16'hA000, 16'hC000, 16'hE000, 16'h0000, 16'h2000, 16'h4000, 16'h6000,
                    16'h7FFF, 16'h5FFF, 16'h3FFF, 16'h1FFF, 16'hFFFF, 16'hDFFF, 16'hBFFF, 16'h9FFF};

        // reset-state outputs for several modes
        divisor = 32'h1000_0000;
        duty    = 8'h40;
        mode    = 2'd0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_saw", 32'(tdata), 32'h8000);
        chk("reset_tvalid", 32'(tvalid), 0);
        mode = 2'd1;
        @(posedge clk);
        #1;
        chk("reset_square", 32'(tdata), 32'h7FFF);
        mode = 2'd3;
        @(posedge clk);
        #1;
        chk("reset_noise", 32'(tdata), 32'h0001);

        // saw ramp with a 5-cycle stall in the middle
        do_reset(32'h1000_0000, 8'h40, 2'd0);
        for (int i = 0; i < 16; i++) push(16'(i * 4096) ^ 16'h8000, 1'b0);
        push(16'h8000, 1'b1);
        run(5);
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_tvalid", 32'(tvalid), 1);
            chk("stall_tdata", 32'(tdata), 32'hD000);
            chk("stall_tuser", 32'(tuser), 0);
        end
        tready = 1'b1;
        run(12);
        drain_check("saw_drain");

        // square 25% duty over one full period plus the wrap sample
        do_reset(32'h0400_0000, 8'h40, 2'd1);
        for (int i = 0; i < 64; i++) push((i < 16) ? 16'h7FFF : 16'h8000, 1'b0);
        push(16'h7FFF, 1'b1);
        run(65);
        drain_check("square_drain");

        do_reset(32'h0400_0000, 8'h00, 2'd1);
        for (int i = 0; i < 8; i++) push(16'h8000, 1'b0);
        run(8);
        drain_check("duty0_drain");

        // triangle
        do_reset(32'h1000_0000, 8'h40, 2'd2);
        for (int i = 0; i < 16; i++) push(tri_tab[i], 1'b0);
        run(16);
        drain_check("tri_drain");

        // config change mid-period takes effect only at the wrap
        do_reset(32'h1000_0000, 8'h40, 2'd0);
        for (int i = 0; i < 16; i++) push(16'(i * 4096) ^ 16'h8000, 1'b0);
        push(16'h7FFF, 1'b1);
        for (int i = 0; i < 3; i++) push(16'h7FFF, 1'b0);
        for (int i = 0; i < 4; i++) push(16'h8000, 1'b0);
        push(16'h7FFF, 1'b1);
        run(4);
        divisor = 32'h2000_0000;
        mode    = 2'd1;
        duty    = 8'h80;
        run(21);
        drain_check("cfg_drain");

        // sync during stall (held 2 cycles) with noise: restart phase, LFSR steps once
        do_reset(32'h1000_0000, 8'h40, 2'd3);
        for (int i = 0; i < 3; i++) push(16'h0001, 1'b0);
        run(3);
        tready = 1'b0;
        sync   = 1'b1;
        cycle();
        cycle();
        sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("sync_stall_tdata", 32'(tdata), 32'h0001);
            chk("sync_stall_tuser", 32'(tuser), 0);
        end
        tready = 1'b1;
        push(16'h0001, 1'b0);
        push(16'h0003, 1'b1);
        for (int i = 0; i < 15; i++) push(16'h0003, 1'b0);
        push(16'h0002, 1'b1);
        run(18);
        drain_check("noise_drain");

        // enable drop only after the next handshake
        do_reset(32'h1000_0000, 8'h40, 2'd0);
        push(16'h8000, 1'b0);
        push(16'h9000, 1'b0);
        run(2);
        tready = 1'b0;
        enable = 1'b0;
        run(3);
        chk("en_hold_tvalid", 32'(tvalid), 1);
        chk("en_hold_tdata", 32'(tdata), 32'hA000);
        tready = 1'b1;
        push(16'hA000, 1'b0);
        cycle();
        chk("en_drop_tvalid", 32'(tvalid), 0);
        enable = 1'b1;
        cycle();
        chk("en_rise_tvalid", 32'(tvalid), 1);
        chk("en_rise_tdata", 32'(tdata), 32'hB000);
        drain_check("en_drain");

        // divisor 0 holds phase, no tuser
        do_reset(32'h0, 8'h40, 2'd0);
        for (int i = 0; i < 5; i++) push(16'h8000, 1'b0);
        run(5);
        drain_check("div0_drain");

        // reset mid-stream clears a pending sync and overrides a pending transfer
        do_reset(32'h1000_0000, 8'h40, 2'd0);
        push(16'h8000, 1'b0);
        push(16'h9000, 1'b0);
        run(2);
        tready = 1'b0;
        sync   = 1'b1;
        cycle();
        sync    = 1'b0;
        tready  = 1'b1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_tvalid", 32'(tvalid), 0);
        chk("midrst_tdata", 32'(tdata), 32'h8000);
        chk("midrst_tuser", 32'(tuser), 0);
        drain_check("midrst_pre_drain");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_release_tvalid", 32'(tvalid), 1);
        push(16'h8000, 1'b0);
        push(16'h9000, 1'b0);
        push(16'hA000, 1'b0);
        run(3);
        drain_check("midrst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
